instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating statistics counters.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1  request valid; in_ready  output  1  request accepted when both high.
REQ-005 SHALL have ports: in_fmt  input  3  format code 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-006 SHALL have ports: in_opcode  input  7; in_rd, in_rs1, in_rs2  input  5 each; in_funct3  input  3; in_funct7  input  7.
REQ-007 SHALL have ports: in_imm  input  32  signed immediate (U: full 32-bit value with low 12 bits zero).
REQ-008 SHALL have ports: out_valid  output  1; out_ready  input  1; out_instr  output  32  encoded word; out_err  output  1  range/format error flag for that word.
REQ-009 SHALL have ports: enc_count, err_count  output  CNT_W  words delivered and errored words delivered.

Function
REQ-010 SHALL pack fields per RV32I: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-011 SHALL pack B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}, J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}, U as {imm[31:12],rd,opcode}.
REQ-012 SHALL encode illegal in_fmt as out_instr 32'h0.
REQ-013 SHALL register each accepted request into a 2-entry output FIFO; latency from accept to out_valid is exactly 1 cycle when FIFO empty.
REQ-014 SHALL drive in_ready = FIFO not full, independent of in_valid; combinational path from out_ready to in_ready is not permitted.
REQ-015 SHALL present the FIFO head on out_instr/out_err with out_valid = FIFO not empty; head holds stable until out_valid && out_ready.
REQ-016 SHALL support simultaneous accept and deliver in one cycle when FIFO is full-minus-0..1 entries, preserving order; full FIFO with out_ready high accepts no new entry that cycle.
REQ-017 SHALL increment enc_count on each delivery and err_count on each delivery with out_err=1; both saturate at all-ones, never wrap.

Reset
REQ-018 SHALL on rst clear FIFO pointers, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0; in_ready=1 from the first cycle after rst deasserts.
REQ-019 SHALL discard any in-flight FIFO contents when rst asserts mid-operation.

Configuration
REQ-020 SHALL compile range checking under macro INSTR_ENCODER_RANGE_CHECK_EN.
REQ-021 With the macro: out_err=1 if I/S imm outside [-2048,2047]; B outside [-4096,4094] or imm[0]=1; J outside [-1048576,1048574] or imm[0]=1; U imm[11:0]!=0; illegal fmt. Word still encoded from truncated bits.
REQ-022 Without the macro: out_err tied 0, err_count tied 0, immediates silently truncated.

Structure
REQ-023 SHALL place the format code enum, opcode constants and NOP constant 32'h00000013 in the shared CPU package used by the decode-side immediate logic.
REQ-024 SHALL implement packing as a combinational function inside the module; the 2-entry FIFO SHALL be sub-module enc_skid_fifo.

Verification
REQ-025 I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> out_instr 0x00500093 one cycle later, out_err=0.
REQ-026 S, opcode 0x23, rs1=3, rs2=2, f3=2, imm=8 -> 0x0021A423; B, opcode 0x63, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
REQ-027 J, opcode 0x6F, rd=1, imm=8 -> 0x008000EF; U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-028 With macro: I imm=2048 -> out_err=1, err_count=1; B imm=6 accepted, imm=7 -> out_err=1; without macro both out_err=0.
REQ-029 Hold out_ready=0, push 3 requests -> in_ready low after 2 accepts; release -> words delivered in order, enc_count=2 then 3.
REQ-030 Assert rst with FIFO holding 2 entries -> out_valid=0 and counters 0 next cycle; no stale word delivered afterward.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared CPU encoding package: instruction format codes, base opcodes
// and the canonical NOP word. Used by the encoder and by the decode-side
// immediate logic.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Encoded word plus its error flag, as carried through the output FIFO.
  localparam int ENC_W = 33;

endpackage

// File: rtl/enc_skid_fifo.sv
// Two-entry output FIFO. full/empty come straight from the occupancy
// register, so the consumer's ready never reaches the producer's ready
// combinationally.
module enc_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = data_i;
      wr_d        = ~wr_q;
    end
    if (pop_ok) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // State registers; reset drops any in-flight entries and zeroes storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word,
// queues it in a 2-entry FIFO and counts delivered / errored words.
// Define INSTR_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit
// their format; otherwise immediates are silently truncated and no error
// is ever reported.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Field packing; the immediate is always cut down to the format's bits.
  function automatic logic [31:0] pack(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    case (fmt)
      FMT_R:   pack = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   pack = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   pack = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   pack = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   pack = {imm[31:12], rd, op};
      FMT_J:   pack = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: pack = 32'h0;
    endcase
  endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // True when the immediate cannot be represented exactly by the format.
  function automatic logic range_err(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] s;
    s = $signed(imm);
    case (fmt)
      FMT_R:        range_err = 1'b0;
      FMT_I, FMT_S: range_err = (s < -32'sd2048) || (s > 32'sd2047);
      FMT_B:        range_err = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
      FMT_J:        range_err = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'h0);
      default:      range_err = 1'b1;
    endcase
  endfunction
`endif

  logic [ENC_W-1:0] enc_word;
  logic [ENC_W-1:0] head;
  logic             fifo_full, fifo_empty;
  logic             deliver;
  logic             new_err;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign new_err = range_err(in_fmt, in_imm);
`else
  assign new_err = 1'b0;
`endif

  assign enc_word = {new_err,
                     pack(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                          in_funct3, in_funct7, in_imm)};

  enc_skid_fifo #(.W(ENC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && in_ready),
    .data_i  (enc_word),
    .pop_i   (deliver),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign out_instr = head[31:0];
  assign out_err   = head[32];
  assign deliver   = out_valid && out_ready;

  logic [CNT_W-1:0] enc_q, enc_d;

  // Delivered-word counter, saturating at all-ones.
  always_comb begin
    enc_d = enc_q;
    if (deliver && (enc_q != '1)) enc_d = enc_q + 1'b1;
  end

  // Delivered-word counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) enc_q <= '0;
    else     enc_q <= enc_d;
  end

  assign enc_count = enc_q;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic [CNT_W-1:0] err_q, err_d;

  // Errored-word counter, saturating at all-ones.
  always_comb begin
    err_d = err_q;
    if (deliver && out_err && (err_q != '1)) err_d = err_q + 1'b1;
  end

  // Errored-word counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors with literal expectations plus
// a queue-based reference model checked every cycle on the falling edge.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready, out_err;
  logic [31:0]   out_instr;
  logic [CW-1:0] enc_count, err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] w; logic e; } exp_t;
  exp_t q[$];
  int   m_enc = 0, m_err = 0;

  function automatic longint unsigned fld(input logic [31:0] v, input int hi, input int lo);
    return (longint'(v) >> lo) & ((64'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    exp_t r;
    longint unsigned w;
    longint v;
    longint unsigned regs;
    v    = longint'($signed(imm));
    regs = (longint'(rs2) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12) | longint'(op);
    w = 0;
    r.e = 1'b0;
    case (f)
      3'd0: w = (longint'(f7) << 25) | regs | (longint'(rd) << 7);
      3'd1: begin
        w = (fld(imm, 11, 0) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12)
          | (longint'(rd) << 7) | longint'(op);
        r.e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (fld(imm, 11, 5) << 25) | regs | (fld(imm, 4, 0) << 7);
        r.e = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | regs
          | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
        r.e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin
        w = (longint'(imm) & 64'hFFFF_F000) | (longint'(rd) << 7) | longint'(op);
        r.e = (fld(imm, 11, 0) != 0);
      end
      3'd5: begin
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
          | (fld(imm, 19, 12) << 12) | (longint'(rd) << 7) | longint'(op);
        r.e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin w = 0; r.e = 1'b1; end
    endcase
    r.w = w[31:0];
    r.e = r.e && RC;
    return r;
  endfunction

  // Compare process: outputs are stable mid-cycle; then advance the model
  // by what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_instr", out_instr, 0);
      chk("rst out_err", out_err, 0);
      chk("rst enc_count", enc_count, 0);
      chk("rst err_count", err_count, 0);
    end else begin
      chk("mdl out_valid", out_valid, q.size() > 0);
      chk("mdl in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("mdl out_instr", out_instr, q[0].w);
        chk("mdl out_err", out_err, q[0].e);
      end
      chk("mdl enc_count", enc_count, m_enc);
      chk("mdl err_count", err_count, m_err);
      if (out_valid && out_ready && q.size() > 0) begin
        if (m_enc < (1 << CW) - 1) m_enc++;
        if (q[0].e && m_err < (1 << CW) - 1) m_err++;
        void'(q.pop_front());
      end
      if (in_valid && in_ready)
        q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called at edge+1; returns at edge+1 right after the accepting edge.
  task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n = 0;
    set_in(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL push timeout: in_ready stayed 0 for 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One request into an empty FIFO, literal check of the head, then drain it.
  task automatic lit(input string nm, input logic [2:0] f, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                     input logic [31:0] w, input logic e);
    push(f, op, rd, rs1, rs2, f3, f7, imm);
    chk({nm, " valid"}, out_valid, 1);
    chk({nm, " word"}, out_instr, w);
    chk({nm, " err"}, out_err, e);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("in_ready after rst", in_ready, 1);

    // range-check vectors first so err_count starts from zero
    lit("I imm2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, RC);
    chk("err_count after I2048", err_count, RC ? 1 : 0);
    lit("B imm6", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0000_0363, 1'b0);
    lit("B imm7", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0000_0363, RC);

    lit("I addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    lit("S sw", 3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0021_A423, 1'b0);
    lit("B neg4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    lit("J jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    lit("U lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    lit("R add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0);
    lit("R sub", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
    lit("fmt6", 3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1, 32'h0000_0000, RC);
    lit("U lowbits", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, RC);

    // backpressure: two accepts fill the FIFO, third waits, order kept
    reset_pulse();
    push(3'd0, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    push(3'd0, 7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    set_in(3'd0, 7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    chk("full in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("full hold in_ready", in_ready, 0);
    chk("full head word", out_instr, 32'h0000_00B3);
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("third accept wait", n < 20, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("enc_count two", enc_count, 2);
    repeat (2) @(posedge clk); #1;
    chk("enc_count three", enc_count, 3);
    chk("drained valid", out_valid, 0);

    // reset with two entries in flight
    out_ready = 1'b0;
    push(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    push(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    chk("pre-rst valid", out_valid, 1);
    rst = 1'b1; #1;
    chk("mid rst valid", out_valid, 0);
    chk("mid rst enc", enc_count, 0);
    @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no stale valid", out_valid, 0);
    chk("no stale enc", enc_count, 0);

    // saturation: 20 deliveries on a 4-bit counter
    for (int i = 0; i < 20; i++)
      push(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 300));
    repeat (3) @(posedge clk); #1;
    chk("enc_count saturated", enc_count, 15);
    chk("err_count after sat run", err_count, RC ? 13 : 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
